// File: rtl/sha256d_engine.sv
// sha256d_engine: iterative SHA-256 / SHA-256d core, one round per clock.
// Define SHA256D_MIDSTATE_EN to reuse the first-block midstate across jobs.
module sha256d_engine #(
    parameter int MSG_BITS = 640
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dbl,
    input  logic [MSG_BITS-1:0] msg,
    output logic                busy,
    output logic                done,
    output logic [255:0]        hash
);

    localparam int NBLK  = (MSG_BITS + 64) / 512 + 1;
    localparam int PBITS = NBLK * 512;
    localparam int BW    = $clog2(NBLK + 1);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ROUND, S_ADD, S_DONE
    } state_t;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Padding is pure wiring: message, 0x80, zeros, 64-bit length.
    function automatic logic [PBITS-1:0] pad(input logic [MSG_BITS-1:0] m);
        logic [PBITS-1:0] p;
        p = '0;
        p[PBITS-1 -: MSG_BITS] = m;
        p[PBITS-MSG_BITS-1 -: 8] = 8'h80;
        p[63:0] = 64'(MSG_BITS);
        return p;
    endfunction

    function automatic logic [511:0] blk_of(input logic [PBITS-1:0] p,
                                            input logic [BW-1:0] b);
        logic [PBITS-1:0] s;
        s = p << {b, 9'd0};
        return s[PBITS-1 -: 512];
    endfunction

    function automatic logic [511:0] head(input logic [MSG_BITS-1:0] m);
        logic [PBITS-1:0] p;
        p = pad(m);
        return p[PBITS-1 -: 512];
    endfunction

    state_t              state_q, state_d;
    logic [BW-1:0]       blk_q, blk_d;
    logic [5:0]          rnd_q, rnd_d;
    logic                sec_q, sec_d;
    logic                dbl_q, dbl_d;
    logic [MSG_BITS-1:0] msg_q, msg_d;
    logic [31:0]         hs_q [8];
    logic [31:0]         hs_d [8];
    logic [31:0]         v_q [8];
    logic [31:0]         v_d [8];
    logic [31:0]         w_q [16];
    logic [31:0]         w_d [16];
    logic [255:0]        hash_q, hash_d;

    logic [31:0]         hn [8];
    logic [255:0]        dig;
    logic [511:0]        blkw, secw;
    logic [31:0]         t1, t2, wnew;
    logic                last;

`ifdef SHA256D_MIDSTATE_EN
    logic [511:0]        mid_m_q, mid_m_d;
    logic [31:0]         mid_h_q [8];
    logic [31:0]         mid_h_d [8];
    logic                mid_v_q, mid_v_d;
    logic                hit;

    assign hit = (NBLK >= 2) && mid_v_q && (head(msg) == mid_m_q);
`endif

    always_comb begin
        dig = '0;
        for (int i = 0; i < 8; i++) begin
            hn[i] = hs_q[i] + v_q[i];
            dig[255-32*i -: 32] = hn[i];
        end
        secw = {dig, 8'h80, 184'd0, 64'd256};
        blkw = blk_of(pad(msg_q), blk_q);
        t1 = v_q[7] + bsig1(v_q[4])
           + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
           + K[rnd_q] + w_q[0];
        t2 = bsig0(v_q[0])
           + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        wnew = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
        last = (blk_q == BW'(NBLK - 1));
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        rnd_d   = rnd_q;
        sec_d   = sec_q;
        dbl_d   = dbl_q;
        msg_d   = msg_q;
        hs_d    = hs_q;
        v_d     = v_q;
        w_d     = w_q;
        hash_d  = hash_q;
`ifdef SHA256D_MIDSTATE_EN
        mid_m_d = mid_m_q;
        mid_h_d = mid_h_q;
        mid_v_d = mid_v_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    msg_d   = msg;
                    dbl_d   = dbl;
                    sec_d   = 1'b0;
                    blk_d   = '0;
                    hs_d    = IV;
`ifdef SHA256D_MIDSTATE_EN
                    if (hit) begin
                        blk_d = BW'(1);
                        hs_d  = mid_h_q;
                    end
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                v_d   = hs_q;
                rnd_d = '0;
                // The second-hash block was already placed in w_q by ADD.
                if (!sec_q) begin
                    for (int i = 0; i < 16; i++)
                        w_d[i] = blkw[511-32*i -: 32];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                v_d[0] = t1 + t2;
                v_d[1] = v_q[0];
                v_d[2] = v_q[1];
                v_d[3] = v_q[2];
                v_d[4] = v_q[3] + t1;
                v_d[5] = v_q[4];
                v_d[6] = v_q[5];
                v_d[7] = v_q[6];
                for (int i = 0; i < 15; i++)
                    w_d[i] = w_q[i+1];
                w_d[15] = wnew;
                rnd_d   = rnd_q + 6'd1;
                if (rnd_q == 6'd63)
                    state_d = S_ADD;
            end
            S_ADD: begin
`ifdef SHA256D_MIDSTATE_EN
                if (!sec_q && blk_q == '0) begin
                    mid_m_d = head(msg_q);
                    mid_h_d = hn;
                    mid_v_d = 1'b1;
                end
`endif
                if (!sec_q && !last) begin
                    hs_d    = hn;
                    blk_d   = blk_q + BW'(1);
                    state_d = S_LOAD;
                end else if (!sec_q && dbl_q) begin
                    hs_d  = IV;
                    sec_d = 1'b1;
                    for (int i = 0; i < 16; i++)
                        w_d[i] = secw[511-32*i -: 32];
                    state_d = S_LOAD;
                end else begin
                    hs_d    = hn;
                    hash_d  = dig;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            rnd_q   <= '0;
            sec_q   <= 1'b0;
            dbl_q   <= 1'b0;
            msg_q   <= '0;
            hs_q    <= IV;
            v_q     <= '{default: '0};
            w_q     <= '{default: '0};
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            rnd_q   <= rnd_d;
            sec_q   <= sec_d;
            dbl_q   <= dbl_d;
            msg_q   <= msg_d;
            hs_q    <= hs_d;
            v_q     <= v_d;
            w_q     <= w_d;
            hash_q  <= hash_d;
        end
    end

`ifdef SHA256D_MIDSTATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_m_q <= '0;
            mid_h_q <= '{default: '0};
            mid_v_q <= 1'b0;
        end else begin
            mid_m_q <= mid_m_d;
            mid_h_q <= mid_h_d;
            mid_v_q <= mid_v_d;
        end
    end
`endif

    assign busy = (state_q == S_LOAD) || (state_q == S_ROUND) ||
                  (state_q == S_ADD);
    assign done = (state_q == S_DONE);
    assign hash = hash_q;

endmodule

// File: doc/sha256d_engine.md
SHA256D_ENGINE -- requirements
Module: sha256d_engine

Interface
REQ-001 SHALL have parameter MSG_BITS, default 640: message length in bits; multiple of 8, range 8..1984.
REQ-002 SHALL derive localparam NBLK = (MSG_BITS+64)/512 + 1: padded block count for the first hash.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: job request.
REQ-006 SHALL have port dbl, input, 1: 1 = SHA-256d (hash of hash), 0 = single SHA-256.
REQ-007 SHALL have port msg, input, MSG_BITS: message; msg[MSG_BITS-1] is the first bit.
REQ-008 SHALL have port busy, output, 1: job in progress.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port hash, output, 256: digest; H0 in hash[255:224], H7 in hash[31:0].

Function
REQ-011 SHALL accept start only in IDLE or DONE; msg and dbl are captured on the accepting edge; start while busy is ignored.
REQ-012 SHALL apply standard padding fixed at elaboration: message, 0x80, zeros, 64-bit big-endian MSG_BITS.
REQ-013 SHALL use states IDLE, LOAD (1 cycle), ROUND (64 cycles, one round per cycle, 16-word rolling schedule), ADD (1 cycle, H += a..h), DONE (1 cycle).
REQ-014 SHALL go ADD -> LOAD while blocks remain; after the last first-hash block, go ADD -> LOAD for one second-hash block if dbl=1, otherwise go to DONE.
REQ-015 SHALL build the second-hash block as the 256-bit digest || 0x80 || zeros || 64'd256, with H reinitialised to the IV.
REQ-016 SHALL give a latency from the accepting edge to done=1 of 66*(NBLK+dbl) cycles; this is 132 for MSG_BITS=640 single and 198 for double.
REQ-017 SHALL drive busy=1 in LOAD, ROUND and ADD, and busy=0 in IDLE and DONE.
REQ-018 SHALL update hash in the DONE cycle and hold it until the next DONE.
REQ-019 SHALL treat a start in the DONE cycle as a new accept (back-to-back jobs, no idle gap).
REQ-020 SHALL use modulo-2^32 arithmetic throughout; the round counter is 6 bits and its wrap 63->0 coincides with ROUND->ADD.

Reset
REQ-021 SHALL, while rst_n=0, force state=IDLE, busy=0, done=0, hash=0 and H=IV, and clear the midstate-valid flag.
REQ-022 SHALL abort a job in progress on reset assertion with no done pulse; the first start after release is a fresh job.

Configuration
REQ-023 SHALL, with SHA256D_MIDSTATE_EN defined, store the first 512 message bits and the post-block-0 H when block 0's ADD completes, and set midstate-valid.
REQ-024 SHALL, with SHA256D_MIDSTATE_EN defined, NBLK>=2, midstate-valid=1 and the accepted msg's first 512 bits equal to the stored bits, start at block 1 with H=stored midstate; latency is then reduced by 66.
REQ-025 SHALL, without SHA256D_MIDSTATE_EN, include no midstate storage and always compute every block.

Verification
REQ-026 SHALL cover: MSG_BITS=24, msg="abc", dbl=0 -> hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, done at +66.
REQ-027 SHALL cover: MSG_BITS=24, "abc", dbl=1 -> hash=4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358, done at +132.
REQ-028 SHALL cover: MSG_BITS=640, Bitcoin genesis header, dbl=1 -> hash=6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000, done at +198.
REQ-029 SHALL cover: MIDSTATE_EN, genesis header then same header with nonce changed -> second job done at +132 with correct digest; header with changed first word -> +198.
REQ-030 SHALL cover: start pulsed at +10 of a running job -> ignored, single done, hash unchanged by the extra pulse.
REQ-031 SHALL cover: rst_n low at round 30 -> busy=0, done=0, hash=0; the next "abc" job gives the REQ-026 result at +66.
